// File: rtl/dtc_vote_accumulator.sv
// Majority-vote accumulator: counts 2-bit class votes over WINDOW samples, emits winner/count/tie.
// Optional DTC_VOTE_FLUSH_EN adds a flush input that closes a partial window early.
module dtc_vote_accumulator #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_class,
  output logic [CNT_W-1:0] out_count,
  output logic             out_tie
`ifdef DTC_VOTE_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  logic [CNT_W-1:0] samples;
  logic             in_fire, out_fire, last_sample, flush_hit, decide;
  logic [1:0]       win_class;
  logic [CNT_W-1:0] win_count;
  logic             win_tie;

  assign in_ready    = (state == ACCUM);
  assign out_valid   = (state == EMIT);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign last_sample = in_fire && (samples == CNT_W'(WINDOW - 1));

`ifdef DTC_VOTE_FLUSH_EN
  // An empty window (nothing stored, nothing arriving) has no decision to make.
  assign flush_hit = (state == ACCUM) && flush && ((samples != '0) || in_fire);
`else
  assign flush_hit = 1'b0;
`endif

  assign decide = last_sample || flush_hit;

  // Counts as they will be after this edge, so the decision includes the arriving sample.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i] + CNT_W'(in_fire && (in_class == 2'(i)));
    end
  end

  always_comb begin
    win_class = 2'd0;
    win_count = cnt_nxt[0];
    win_tie   = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (cnt_nxt[i] > win_count) begin
        win_class = 2'(i);
        win_count = cnt_nxt[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) != win_class) && (cnt_nxt[i] == win_count)) begin
        win_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (decide)    state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = ACCUM;
      default:                state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      samples   <= '0;
      out_class <= 2'd0;
      out_count <= '0;
      out_tie   <= 1'b0;
    end else begin
      if (out_fire) begin
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
        samples <= '0;
      end else if (in_fire) begin
        for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
        samples <= samples + 1'b1;
      end
      if (decide) begin
        out_class <= win_class;
        out_count <= win_count;
        out_tie   <= win_tie;
      end
    end
  end

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
// Scoreboard bench for dtc_vote_accumulator (WINDOW=4 main instance, WINDOW=1 side instance).
module tb_dtc_vote_accumulator;

  localparam int WIN = 4;

  typedef struct {
    logic [1:0] cls;
    logic [7:0] cnt;
    logic       tie;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_tie;
  logic [1:0] in_class, out_class;
  logic [7:0] out_count;
`ifdef DTC_VOTE_FLUSH_EN
  logic       flush;
`endif

  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_tie1;
  logic [1:0] in_class1, out_class1;
  logic [7:0] out_count1;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  exp_t        sb_q[$];
  int unsigned m_cnt[4];
  int unsigned m_n;

  always #5 clk = ~clk;

  dtc_vote_accumulator #(.WINDOW(WIN), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_count(out_count), .out_tie(out_tie)
`ifdef DTC_VOTE_FLUSH_EN
    , .flush(flush)
`endif
  );

`ifdef DTC_VOTE_FLUSH_EN
  logic flush1 = 1'b0;
`endif
  dtc_vote_accumulator #(.WINDOW(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_class(in_class1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_class(out_class1), .out_count(out_count1), .out_tie(out_tie1)
`ifdef DTC_VOTE_FLUSH_EN
    , .flush(flush1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_n = 0;
  endtask

  // Reference: argmax with lowest index winning ties; decide at WIN samples or on a non-empty flush.
  task automatic model_step(input bit xf, input logic [1:0] c, input bit fl);
    exp_t e;
    int unsigned best;
    if (xf) begin
      m_cnt[c]++;
      m_n++;
    end
    if ((m_n == WIN) || (fl && (m_n > 0))) begin
      best = 0;
      for (int i = 1; i < 4; i++) if (m_cnt[i] > m_cnt[best]) best = i;
      e.cls = 2'(best);
      e.cnt = 8'(m_cnt[best]);
      e.tie = 1'b0;
      for (int i = 0; i < 4; i++) if ((i != best) && (m_cnt[i] == m_cnt[best])) e.tie = 1'b1;
      sb_q.push_back(e);
      model_clear();
    end
  endtask

  // Entered and left at posedge+1; consecutive calls give back-to-back transfers.
  task automatic xfer(input logic [1:0] c, input bit fl);
    bit done = 0;
    in_valid = 1'b1;
    in_class = c;
`ifdef DTC_VOTE_FLUSH_EN
    flush = fl;
`endif
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_step(1'b1, c, fl);
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("xfer_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef DTC_VOTE_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    sb_q.delete();
    model_clear();
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && !(sb_q.size() == 0 && !out_valid); k++) begin
      @(posedge clk); #1;
    end
    check("drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_class", out_class, e.cls);
        check("out_count", out_count, e.cnt);
        check("out_tie",   out_tie,   e.tie);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] s_cls;
    logic [7:0] s_cnt;
    logic       s_tie;

    rst = 1'b1; in_valid = 1'b0; in_class = 2'd0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_class1 = 2'd0; out_ready1 = 1'b1;
`ifdef DTC_VOTE_FLUSH_EN
    flush = 1'b0;
`endif
    model_clear();

    // 1. reset
    @(posedge clk); #1;
    do_reset(2);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_tie",   out_tie,   0);
    check("rst_in_ready",  in_ready,  1);
    @(posedge clk); #1;

    // 2. majority with latency and single-cycle in_ready drop
    xfer(2, 0); xfer(2, 0); xfer(1, 0); xfer(2, 0);
    @(negedge clk);
    check("lat_out_valid", out_valid, 1);
    check("lat_in_ready",  in_ready,  0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rec_in_ready",  in_ready,  1);
    check("rec_out_valid", out_valid, 0);
    @(posedge clk); #1;

    // 3. tie resolves to lowest class
    xfer(3, 0); xfer(1, 0); xfer(3, 0); xfer(1, 0);
    wait_idle();

    // 3b. WINDOW=1 instance
    in_valid1 = 1'b1; in_class1 = 2'd3;
    @(negedge clk);
    check("w1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_class1 = 2'd0;
    @(negedge clk);
    check("w1_out_valid", out_valid1, 1);
    check("w1_out_class", out_class1, 3);
    check("w1_out_count", out_count1, 1);
    check("w1_out_tie",   out_tie1,   0);
    @(posedge clk); #1;

    // 4. backpressure: outputs frozen, inputs refused
    out_ready = 1'b0;
    xfer(0, 0); xfer(1, 0); xfer(2, 0); xfer(2, 0);
    @(negedge clk);
    s_cls = out_class; s_cnt = out_count; s_tie = out_tie;
    check("bp_out_valid0", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_class = 2'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready",  in_ready,  0);
      check("bp_stable",    {out_class, out_count, out_tie}, {s_cls, s_cnt, s_tie});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0); xfer(0, 0); xfer(0, 0); xfer(1, 0);
    wait_idle();

    // 5. reset mid-window
    xfer(0, 0); xfer(0, 0);
    do_reset(1);
    xfer(3, 0); xfer(3, 0); xfer(3, 0); xfer(3, 0);
    wait_idle();

    // 5b. reset while a decision is pending
    out_ready = 1'b0;
    xfer(1, 0); xfer(1, 0); xfer(1, 0); xfer(1, 0);
    @(negedge clk);
    check("emit_before_rst", out_valid, 1);
    @(posedge clk); #1;
    do_reset(1);
    @(negedge clk);
    check("emit_after_rst", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;

`ifdef DTC_VOTE_FLUSH_EN
    // 6. flush of a partial window, then flush of an empty window
    xfer(1, 0); xfer(0, 0); xfer(1, 0);
    flush = 1'b1;
    @(negedge clk);
    model_step(1'b0, 2'd0, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle();
    flush = 1'b1;
    @(negedge clk);
    model_step(1'b0, 2'd0, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("empty_flush", out_valid, 0);
      @(posedge clk); #1;
    end
`endif

    wait_idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
